// File: rtl/spi_pkg.sv
// Shared state encoding, opcode constants and default widths for the SPI command slave.
package spi_pkg;

  localparam int RX_WIDTH_DEF = 10;
  localparam int TX_WIDTH_DEF = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_e;

  // The first command bit alone decides between the write and read paths.
  function automatic logic is_read_cmd(input logic cmd_msb);
    return cmd_msb == OP_RD_ADDR[1];
  endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// MISO driver: loads one read word and emits it MSB first, one bit per clock,
// holding MISO low whenever no word is being shifted out.
module spi_tx_serializer import spi_pkg::*; #(
  parameter int TX_WIDTH = TX_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stop,
  input  logic                load,
  input  logic [TX_WIDTH-1:0] load_data,
  output logic                miso,
  output logic                last
);

  logic [TX_WIDTH-1:0] shreg_r;
  logic [3:0]          cnt_r;
  logic                miso_r;

  // Load, shift and count; stop wins so an abort silences MISO on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= {TX_WIDTH{1'b0}};
      cnt_r   <= 4'd0;
      miso_r  <= 1'b0;
    end else if (stop) begin
      shreg_r <= {TX_WIDTH{1'b0}};
      cnt_r   <= 4'd0;
      miso_r  <= 1'b0;
    end else if (load) begin
      shreg_r <= load_data;
      cnt_r   <= 4'(TX_WIDTH);
      miso_r  <= 1'b0;
    end else if (cnt_r != 4'd0) begin
      miso_r  <= shreg_r[TX_WIDTH-1];
      shreg_r <= {shreg_r[TX_WIDTH-2:0], 1'b0};
      cnt_r   <= cnt_r - 4'd1;
    end else begin
      miso_r  <= 1'b0;
    end
  end

  assign miso = miso_r;
  assign last = (cnt_r == 4'd1) && !stop;

endmodule

// File: rtl/spi_slave.sv
// SPI command slave: deserializes 10-bit command frames from MOSI and returns
// read data on MISO after a read-address / read-data command pair.
module spi_slave import spi_pkg::*; #(
  parameter int RX_WIDTH = RX_WIDTH_DEF,
  parameter int TX_WIDTH = TX_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                MOSI,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_valid,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  output logic                MISO
);

  localparam logic [3:0] BODY_LAST = 4'(RX_WIDTH - 2);

  spi_state_e          state_r;
  spi_state_e          state_nxt_s;
  logic [3:0]          cnt_r;
  logic [RX_WIDTH-2:0] shift_r;
  logic [RX_WIDTH-1:0] rx_data_r;
  logic                rx_valid_r;
  logic                frame_done_r;
  logic                await_r;
  logic                rd_addr_flag_r;
  logic                armed_r;
  logic                in_body_s;
  logic                shift_s;
  logic                last_bit_s;
  logic                load_s;
  logic                ser_last_s;
  logic                ser_miso_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; SS_n high returns to IDLE from anywhere.
  always_comb begin
    state_nxt_s = state_r;
    if (SS_n) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (armed_r) state_nxt_s = CHK_CMD;
          else         state_nxt_s = IDLE;
        end
        CHK_CMD: begin
          if (!is_read_cmd(MOSI)) state_nxt_s = WRITE;
          else if (rd_addr_flag_r) state_nxt_s = READ_DATA;
          else                     state_nxt_s = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: state_nxt_s = state_r;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Output decode: frame-body shifting, last bit, and read-data capture.
  always_comb begin
    in_body_s = 1'b0;
    case (state_r)
      WRITE, READ_ADD, READ_DATA: in_body_s = 1'b1;
      default:                    in_body_s = 1'b0;
    endcase
    shift_s    = in_body_s && !frame_done_r && !SS_n;
    last_bit_s = shift_s && (cnt_r == 4'd0);
    load_s     = (state_r == READ_DATA) && await_r && tx_valid && !SS_n;
  end

  // Deserializer, command strobe and read handshake. armed_r blocks a frame
  // until SS_n has been seen high after reset, so a frame cut by reset is not resumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r          <= 4'd0;
      shift_r        <= {(RX_WIDTH-1){1'b0}};
      rx_data_r      <= {RX_WIDTH{1'b0}};
      rx_valid_r     <= 1'b0;
      frame_done_r   <= 1'b0;
      await_r        <= 1'b0;
      rd_addr_flag_r <= 1'b0;
      armed_r        <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (SS_n) begin
        armed_r      <= 1'b1;
        cnt_r        <= 4'd0;
        shift_r      <= {(RX_WIDTH-1){1'b0}};
        frame_done_r <= 1'b0;
        await_r      <= 1'b0;
      end else if (state_r == CHK_CMD) begin
        shift_r <= {{(RX_WIDTH-2){1'b0}}, MOSI};
        cnt_r   <= BODY_LAST;
      end else if (last_bit_s) begin
        rx_data_r    <= {shift_r, MOSI};
        rx_valid_r   <= 1'b1;
        frame_done_r <= 1'b1;
        if (state_r == READ_ADD)  rd_addr_flag_r <= 1'b1;
        if (state_r == READ_DATA) await_r        <= 1'b1;
      end else if (shift_s) begin
        shift_r <= {shift_r[RX_WIDTH-3:0], MOSI};
        cnt_r   <= cnt_r - 4'd1;
      end else if (load_s) begin
        await_r <= 1'b0;
      end else if (ser_last_s) begin
        rd_addr_flag_r <= 1'b0;
      end
    end
  end

  spi_tx_serializer #(.TX_WIDTH(TX_WIDTH)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .stop      (SS_n),
    .load      (load_s),
    .load_data (tx_data),
    .miso      (ser_miso_s),
    .last      (ser_last_s)
  );

  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign MISO     = ser_miso_s;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a frame-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, SS_n, MOSI, tx_valid;
  logic [7:0] tx_data;
  logic [9:0] rx_data;
  logic       rx_valid, MISO;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_seen = 0;
  int miso_ones = 0;

  spi_slave #(.RX_WIDTH(10), .TX_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .rx_data(rx_data), .rx_valid(rx_valid), .MISO(MISO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: position in frame, collected word, pending MISO bits.
  localparam int K_WR = 0, K_RA = 1, K_RD = 2;
  int         m_pos = -1;
  int         m_kind = K_WR;
  logic       m_armed = 1'b0, m_flag = 1'b0, m_await = 1'b0;
  logic [9:0] m_word = 10'd0, exp_rx_data = 10'd0;
  logic       exp_rx_valid = 1'b0, exp_miso = 1'b0;
  bit         m_q[$];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pos = -1; m_armed = 1'b0; m_flag = 1'b0; m_await = 1'b0;
      m_word = 10'd0; exp_rx_data = 10'd0; exp_rx_valid = 1'b0; exp_miso = 1'b0;
      m_q.delete();
    end else begin
      exp_rx_valid = 1'b0;
      exp_miso = 1'b0;
      if (SS_n) begin
        m_armed = 1'b1; m_pos = -1; m_await = 1'b0; m_q.delete();
      end else if (m_pos < 0) begin
        if (m_armed) m_pos = 0;
      end else begin
        if (m_q.size() > 0) begin
          exp_miso = m_q.pop_front();
          if (m_q.size() == 0) m_flag = 1'b0;
        end
        if (m_pos < 10) begin
          m_pos++;
          m_word = {m_word[8:0], MOSI};
          if (m_pos == 1) m_kind = !MOSI ? K_WR : (m_flag ? K_RD : K_RA);
          if (m_pos == 10) begin
            exp_rx_valid = 1'b1;
            exp_rx_data = m_word;
            if (m_kind == K_RA) m_flag = 1'b1;
            if (m_kind == K_RD) m_await = 1'b1;
          end
        end else if (m_await && tx_valid) begin
          for (int i = 7; i >= 0; i--) m_q.push_back(tx_data[i]);
          m_await = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    check("rx_valid", 32'(rx_valid), 32'(exp_rx_valid));
    check("rx_data", 32'(rx_data), 32'(exp_rx_data));
    check("MISO", 32'(MISO), 32'(exp_miso));
    if (rx_valid === 1'b1) valid_seen++;
    if (MISO === 1'b1) miso_ones++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Lower SS_n, drive nbits of w MSB first; returns one negedge after the last bit was sampled.
  task automatic frame_bits(input logic [9:0] w, input int nbits);
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
    for (int i = 9; i > 9 - nbits; i--) begin
      @(negedge clk); MOSI = w[i];
    end
    @(negedge clk);
  endtask

  task automatic release_ss;
    SS_n = 1'b1; MOSI = 1'b0;
    @(negedge clk);
  endtask

  // Read frame followed by tx_valid; counts MISO activity to reveal the path taken.
  task automatic read_probe(input logic [9:0] w, input string name, input int exp_ones);
    int ones0;
    frame_bits(w, 10);
    check({name, "_data"}, 32'(rx_data), 32'(w));
    ones0 = miso_ones;
    tx_data = 8'hFF; tx_valid = 1'b1;
    tick(3);
    tx_valid = 1'b0;
    tick(10);
    check({name, "_miso"}, 32'(miso_ones - ones0), 32'(exp_ones));
    release_ss();
  endtask

  int         v0, ones0;
  logic [7:0] got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tick(3);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_miso", 32'(MISO), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Write-address frame 00_1010_0101.
    ones0 = miso_ones;
    frame_bits({OP_WR_ADDR, 8'hA5}, 10);
    check("wr_valid", 32'(rx_valid), 32'h1);
    check("wr_data", 32'(rx_data), 32'h0A5);
    tick(1);
    check("wr_valid_once", 32'(rx_valid), 32'h0);
    release_ss();
    check("wr_miso_quiet", 32'(miso_ones - ones0), 32'h0);

    // Write-data frame with tx_valid asserted throughout: no capture.
    ones0 = miso_ones;
    tx_valid = 1'b1; tx_data = 8'hFF;
    frame_bits({OP_WR_DATA, 8'h5A}, 10);
    check("wd_data", 32'(rx_data), 32'h15A);
    tick(4);
    tx_valid = 1'b0;
    release_ss();
    check("wd_no_capture", 32'(miso_ones - ones0), 32'h0);

    // Read with flag clear takes the read-address path: no MISO.
    read_probe({OP_RD_ADDR, 8'h10}, "rd_addr", 0);

    // Read-data frame, then 0xC3 returned MSB first; tx_valid during shift-out ignored.
    frame_bits({OP_RD_DATA, 8'h00}, 10);
    check("rd_data_cmd", 32'(rx_data), 32'h300);
    tick(2);
    tx_valid = 1'b1; tx_data = 8'hC3;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      got[i] = MISO;
      if (i == 5) begin tx_valid = 1'b1; tx_data = 8'h00; end
      if (i == 3) tx_valid = 1'b0;
    end
    check("miso_c3", 32'(got), 32'hC3);
    tx_valid = 1'b1; tx_data = 8'hFF;
    ones0 = miso_ones;
    tick(4);
    tx_valid = 1'b0;
    check("rd_idle_quiet", 32'(miso_ones - ones0), 32'h0);
    release_ss();

    // Flag cleared by the completed shift-out: next read is an address read again.
    read_probe({OP_RD_ADDR, 8'h11}, "flag_cleared", 0);

    // Abort after 5 bits, then a full frame decodes normally.
    v0 = valid_seen;
    frame_bits({OP_WR_ADDR, 8'hFF}, 5);
    release_ss();
    tick(1);
    check("abort_no_valid", 32'(valid_seen - v0), 32'h0);
    frame_bits({OP_WR_ADDR, 8'hF0}, 10);
    check("post_abort_valid", 32'(rx_valid), 32'h1);
    check("post_abort_data", 32'(rx_data), 32'h0F0);
    release_ss();

    // Reset during shift-out of 0xFF.
    frame_bits({OP_RD_DATA, 8'hFF}, 10);
    tx_valid = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    tick(3);
    check("pre_rst_miso", 32'(MISO), 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_miso", 32'(MISO), 32'h0);
    check("arst_rx_valid", 32'(rx_valid), 32'h0);
    check("arst_rx_data", 32'(rx_data), 32'h0);
    tick(2);
    rst_n = 1'b1;
    // SS_n still low after release: no frame may be decoded.
    v0 = valid_seen;
    for (int i = 0; i < 12; i++) begin
      MOSI = i[0];
      @(negedge clk);
    end
    check("no_frame_after_rst", 32'(valid_seen - v0), 32'h0);
    release_ss();
    tick(1);
    read_probe({OP_RD_DATA, 8'h22}, "flag_rst", 0);
    read_probe({OP_RD_DATA, 8'h33}, "rd_after_rst", 8);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
